// File: rtl/lifo_pkg.sv
// lifo_pkg: shared FSM state encoding and constants for the LIFO burst reader
package lifo_pkg;
    typedef enum logic [1:0] {IDLE, POP, FLUSH, DONE} state_t;
    localparam int DATA_W_DEF = 4;
    localparam logic POP_CODE = 1'b1;
endpackage

// File: rtl/lifo_skid_buf.sv
// lifo_skid_buf: 2-entry valid/ready buffer that passes the incoming word straight through when empty
module lifo_skid_buf #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign in_ready_o  = cnt_q != 2'd2;
    assign out_valid_o = (cnt_q != 2'd0) || in_valid_i;
    assign out_data_o  = (cnt_q != 2'd0) ? head_q : (in_valid_i ? in_data_i : '0);
    assign count_o     = cnt_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // head refills from the input or the tail; a word pushed into an empty buffer and taken at once is never stored
    always_comb begin
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        head_d = (push && (cnt_q == 2'd0 ? !pop : pop)) ? in_data_i :
                 (pop && cnt_q == 2'd2) ? tail_q : head_q;
        tail_d = (push && cnt_q == 2'd1 && !pop) ? in_data_i : tail_q;
    end

    // buffer storage and occupancy
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/lifo_reader.sv
// lifo_reader: drains a LIFO stack in bursts into a valid/ready stream; LIFO_READER_PARITY_EN adds out_par
module lifo_reader
    import lifo_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_BURST_W = 4
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [MAX_BURST_W-1:0] burst_len,
    output logic                   lifo_EN,
    output logic                   lifo_RW,
    input  logic [DATA_W-1:0]      lifo_dataOut,
    input  logic                   lifo_EMPTY,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef LIFO_READER_PARITY_EN
    output logic                   out_par,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   underflow
);
`ifdef LIFO_READER_PARITY_EN
    localparam int BW = DATA_W + 1;
`else
    localparam int BW = DATA_W;
`endif
    state_t                 state_q, state_d;
    logic [MAX_BURST_W-1:0] rem_q, rem_d;
    logic                   drain_q, drain_d, inflight_q, underflow_q, underflow_d, issue;
    logic                   buf_in_ready;
    logic [1:0]             buf_cnt;
    logic [2:0]             occ;
    logic [BW-1:0]          buf_in, buf_out;

    assign occ = {1'b0, buf_cnt} + {2'b0, inflight_q};
`ifdef LIFO_READER_PARITY_EN
    assign buf_in  = {^lifo_dataOut, lifo_dataOut};
    assign out_par = buf_out[DATA_W];
`else
    assign buf_in  = lifo_dataOut;
`endif
    assign out_data  = buf_out[DATA_W-1:0];
    assign lifo_EN   = issue;
    assign lifo_RW   = issue ? POP_CODE : ~POP_CODE;
    assign busy      = (state_q == POP) || (state_q == FLUSH);
    assign done      = state_q == DONE;
    assign underflow = underflow_q;

    lifo_skid_buf #(.W(BW)) u_buf (
        .clk         (clk),
        .rst_i       (Rst),
        .in_valid_i  (inflight_q),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (buf_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (buf_out),
        .count_o     (buf_cnt)
    );

    // next state, pop issue and remaining-count; pops stop while two words are already owed to the sink
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        drain_d     = drain_q;
        underflow_d = underflow_q;
        issue       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d     = POP;
                rem_d       = burst_len;
                drain_d     = burst_len == '0;
                underflow_d = lifo_EMPTY;
            end
            POP: begin
                issue = !Rst && !lifo_EMPTY && buf_in_ready && (drain_q || rem_q != '0) && occ < 3'd2;
                rem_d = (issue && !drain_q) ? rem_q - MAX_BURST_W'(1) : rem_q;
                if ((!drain_q && rem_d == '0) || (lifo_EMPTY && !issue)) state_d = FLUSH;
            end
            FLUSH: if (!inflight_q && buf_cnt == 2'd0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, burst bookkeeping, in-flight pop flag and sticky underflow
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            drain_q     <= 1'b0;
            inflight_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            drain_q     <= drain_d;
            inflight_q  <= issue;
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_lifo_reader.sv
// tb_lifo_reader: random bursts against a queue-based stack and newest-first scoreboard
module tb_lifo_reader;
    logic       clk = 1'b0, Rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [3:0] burst_len = 4'd0, lifo_dataOut = 4'd0, out_data;
    logic       lifo_EN, lifo_RW, lifo_EMPTY = 1'b1, out_valid, busy, done, underflow;
`ifdef LIFO_READER_PARITY_EN
    logic       out_par;
`endif
    logic [3:0] stk[$];
    logic [3:0] exp_q[$];
    logic       push_req = 1'b0;
    logic [3:0] push_val = 4'd0;
    int cyc = 0, pops = 0, xfers = 0, drop = 0, en_cnt = 0, done_cnt = 0, done_cyc = 0, rise_cyc = 0;
    int n_tests = 0, n_fail = 0;
    logic       prev_hold = 1'b0, prev_valid = 1'b0;
    logic [3:0] prev_data = 4'd0;

    lifo_reader dut (
        .clk          (clk),
        .Rst          (Rst),
        .start        (start),
        .burst_len    (burst_len),
        .lifo_EN      (lifo_EN),
        .lifo_RW      (lifo_RW),
        .lifo_dataOut (lifo_dataOut),
        .lifo_EMPTY   (lifo_EMPTY),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
`ifdef LIFO_READER_PARITY_EN
        .out_par      (out_par),
`endif
        .busy         (busy),
        .done         (done),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        return mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) :
               mode == 2 ? 1'($urandom_range(0, 1)) : (k >= 7);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lifo_EN && lifo_RW && stk.size() != 0) begin
            lifo_dataOut <= stk[stk.size()-1];
            void'(stk.pop_back());
            pops <= pops + 1;
        end
        if (push_req) stk.push_back(push_val);
        lifo_EMPTY <= (stk.size() == 0);
    end

    always @(negedge clk) begin
        #1;
        if (Rst) begin
            check("en_in_rst", lifo_EN, 0);
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (lifo_EN) en_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (busy) check("pops_ahead_le2", int'(pops - xfers - drop <= 2), 1);
            if (out_valid && out_ready) begin
                check("word_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
                xfers++;
            end
`ifdef LIFO_READER_PARITY_EN
            if (out_valid) check("out_par", out_par, ^out_data);
`endif
            prev_hold  = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_data  = out_data;
        end
    end

    task automatic push(input logic [3:0] v);
        @(negedge clk);
        push_req = 1'b1;
        push_val = v;
        @(negedge clk);
        push_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        Rst = 1'b0;
        exp_q.delete();
        drop = pops - xfers;
        #1;
        check("rst_lifo_EN", lifo_EN, 0);
        check("rst_lifo_RW", lifo_RW, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underflow", underflow, 0);
    endtask

    task automatic burst(input int len, input int mode);
        int n, d0, e0, s0;
        bit was_empty, got;
        @(negedge clk);
        was_empty = (stk.size() == 0);
        n = (len == 0 || len > stk.size()) ? stk.size() : len;
        for (int i = 0; i < n; i++) exp_q.push_back(stk[stk.size()-1-i]);
        d0 = done_cnt;
        e0 = en_cnt;
        s0 = cyc;
        start = 1'b1;
        burst_len = 4'(len);
        out_ready = rdy(mode, 0);
        got = 1'b0;
        for (int k = 1; k < 200 && !got; k++) begin
            @(negedge clk);
            start = (mode == 3 && k == 5);
            out_ready = rdy(mode, k);
            #2;
            got = (done_cnt != d0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("all_words_out", exp_q.size(), 0);
        check("pops_issued", en_cnt - e0, n);
        check("underflow", underflow, int'(was_empty));
        if (n == 0) check("done_latency", done_cyc - s0, 3);
        if (n != 0 && mode == 0) check("first_valid_latency", rise_cyc - s0, 2);
    endtask

    initial begin
        int x0;
        do_reset();
        for (int i = 0; i < 4; i++) push(4'(2 * i));
        burst(0, 0);
        for (int i = 0; i < 4; i++) push(4'(2 * i));
        burst(2, 0);
        check("left_after_len2", stk.size(), 2);
        burst(0, 0);
        burst(0, 0);
        for (int i = 0; i < 4; i++) push(4'(2 * i + 1));
        burst(0, 1);
        for (int i = 0; i < 4; i++) push(4'(2 * i));
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_q.push_back(stk[stk.size()-1-i]);
        x0 = xfers;
        start = 1'b1;
        burst_len = 4'd0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && xfers == x0; k++) begin
            @(negedge clk);
            start = 1'b0;
            #2;
        end
        check("first_word_before_rst", xfers - x0, 1);
        do_reset();
        burst(0, 0);
        push(4'd9);
        push(4'd12);
        burst(0, 3);
        for (int it = 0; it < 12; it++) begin
            int np;
            np = $urandom_range(0, 5);
            for (int i = 0; i < np; i++) push(4'($urandom_range(0, 15)));
            burst($urandom_range(0, 7), $urandom_range(0, 2));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lifo_reader.md
LIFO_READER -- requirements
Module: lifo_reader

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 4, the data width; it SHALL match the stack's data port.
REQ-002 The block SHALL provide parameter MAX_BURST_W, default 4, the width of the burst length field.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a drain burst; accepted only in IDLE.
REQ-006 burst_len  input  MAX_BURST_W  entries to pop; 0 means pop until the stack is empty; sampled when start is accepted.
REQ-007 lifo_EN  output  1  stack enable.
REQ-008 lifo_RW  output  1  stack direction; 1 = pop.
REQ-009 lifo_dataOut  input  DATA_W  stack read data.
REQ-010 lifo_EMPTY  input  1  stack empty flag.
REQ-011 out_data  output  DATA_W  popped word, presented newest-first.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  sink accepts the word.
REQ-014 busy  output  1  a burst is in progress.
REQ-015 done  output  1  one-cycle pulse at burst completion.
REQ-016 underflow  output  1  sticky flag: start was accepted while lifo_EMPTY was high; cleared by the next accepted start or by Rst.

Function
REQ-017 Stack contract: a pop is lifo_EN=1 and lifo_RW=1 on a rising clk edge with lifo_EMPTY=0; lifo_dataOut is valid the cycle after that edge.
REQ-018 FSM states: IDLE, POP, FLUSH, DONE.
REQ-019 IDLE: lifo_EN=0 and lifo_RW=0; start moves the FSM to POP, loads the remaining-count from burst_len, and updates underflow.
REQ-020 POP: assert lifo_EN=1 and lifo_RW=1 only when lifo_EMPTY=0, remaining-count is not 0 (or drain mode is active), and the 2-entry output buffer occupancy plus in-flight pops is below 2.
REQ-021 Each issued pop decrements remaining-count and sets an in-flight flag; the word is captured into the output buffer the following cycle.
REQ-022 POP moves to FLUSH when remaining-count reaches 0, or when lifo_EMPTY=1 with no pop issued in that cycle.
REQ-023 FLUSH moves to DONE once there is no in-flight pop and the output buffer is empty; DONE returns to IDLE after one cycle.
REQ-024 done SHALL be 1 only in DONE; busy SHALL be 1 in POP and FLUSH.
REQ-025 Output stream: out_valid=1 whenever the buffer is non-empty; a word transfers when out_valid and out_ready are both 1; out_data and out_valid SHALL be held stable until that transfer.
REQ-026 A capture and a transfer in the same cycle SHALL leave occupancy unchanged, with no bubble and no loss.
REQ-027 Words SHALL leave the block in pop order, so the last-pushed word is first out.
REQ-028 start in any state other than IDLE SHALL be ignored.
REQ-029 Burst on an empty stack: underflow=1, no pop is issued, POP->FLUSH->DONE, and done pulses 3 cycles after start.
REQ-030 With out_ready held at 1 and a non-empty stack, the block SHALL sustain one pop per cycle; the first out_valid appears 2 cycles after start.

Reset
REQ-031 Rst=1 at a clk edge SHALL force: FSM to IDLE; lifo_EN=0; lifo_RW=0; out_valid=0; out_data=0; busy=0; done=0; underflow=0; buffer and in-flight flag cleared.
REQ-032 Rst mid-burst SHALL discard buffered and in-flight words; no pop SHALL be issued in the reset cycle.

Configuration
REQ-033 Macro LIFO_READER_PARITY_EN defined: add output out_par (1 bit), the even parity of out_data, registered alongside the buffer entry and stable with out_valid.
REQ-034 Macro LIFO_READER_PARITY_EN undefined: out_par is absent and all other behaviour is identical.

Structure
REQ-035 Package lifo_pkg SHALL hold the FSM state enum typedef, the DATA_W default, and the constant POP_CODE = 1 for lifo_RW.
REQ-036 The 2-entry output buffer SHALL be a sub-module lifo_skid_buf with valid/ready on both sides.

Verification
REQ-037 Pushes 0,2,4,6; start with burst_len=0; out_ready=1 -> out_data sequence 6,4,2,0; done pulses once; underflow=0.
REQ-038 Same stack; burst_len=2 -> output 6,4; then start again with burst_len=0 -> output 2,0.
REQ-039 Empty stack; start -> underflow=1, no lifo_EN pulse, done 3 cycles after start.
REQ-040 Four entries; out_ready toggles 1,0,0,1,... -> no loss or duplicate, out_data stable while stalled, at most 2 pops ahead of the sink.
REQ-041 Rst asserted in POP after 1 word is output -> all outputs at reset values next cycle; a following burst outputs the remaining words in order.
REQ-042 start pulsed during FLUSH -> ignored; exactly one done pulse.
